// File: rtl/trig_pkg.sv
// Shared constants, FSM state encoding and helpers for the trig LUT sequencer.
package trig_pkg;

  localparam int unsigned FUNC_W   = 3;
  localparam int unsigned QUAD_W   = 2;
  localparam int unsigned FN_COUNT = 6;
  localparam int unsigned QUAD_DEG = 90;
  localparam int unsigned FULL_DEG = 360;

  localparam logic [FUNC_W-1:0] FN_SIN = 3'd0;
  localparam logic [FUNC_W-1:0] FN_COS = 3'd1;
  localparam logic [FUNC_W-1:0] FN_TAN = 3'd2;
  localparam logic [FUNC_W-1:0] FN_CSC = 3'd3;
  localparam logic [FUNC_W-1:0] FN_SEC = 3'd4;
  localparam logic [FUNC_W-1:0] FN_COT = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REDUCE,
    ST_ISSUE,
    ST_CAPTURE,
    ST_RESP
  } state_e;

  // One-hot LUT enable for a (valid) function code.
  function automatic logic [FN_COUNT-1:0] fn_onehot(input logic [FUNC_W-1:0] fn);
    fn_onehot = FN_COUNT'(1) << fn;
  endfunction

endpackage

// File: rtl/trig_lut_sequencer_if.sv
// Request/response bus between the two requesters and the trig LUT sequencer.
interface trig_lut_sequencer_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ANGLE_W    = 9
);
  import trig_pkg::*;

  logic [1:0]              req_valid;
  logic [1:0]              req_ready;
  logic [FUNC_W-1:0]       req_func0;
  logic [FUNC_W-1:0]       req_func1;
  logic [ANGLE_W-1:0]      req_angle0;
  logic [ANGLE_W-1:0]      req_angle1;
  logic                    resp_valid;
  logic                    resp_ready;
  logic [2*DATA_WIDTH-1:0] resp_data;
  logic                    resp_id;
  logic                    resp_err;

  modport master (
    output req_valid, req_func0, req_func1, req_angle0, req_angle1, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_id, resp_err
  );

  modport slave (
    input  req_valid, req_func0, req_func1, req_angle0, req_angle1, resp_ready,
    output req_ready, resp_valid, resp_data, resp_id, resp_err
  );

endinterface

// File: rtl/trig_angle_reduce.sv
// Iterative angle reduction: subtracts 90 degrees per cycle until the remainder
// is below 90, then presents quadrant and reference angle while done_c is high.
module trig_angle_reduce
  import trig_pkg::*;
#(
  parameter int unsigned ANGLE_W    = 9,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ANGLE_W-1:0]    angle,
  output logic                  done_c,
  output logic [QUAD_W-1:0]     quad_c,
  output logic [DATA_WIDTH-1:0] ref_c
);

  logic [ANGLE_W-1:0] rem_q, rem_d;
  logic [QUAD_W-1:0]  quad_q, quad_d;
  logic               busy_q, busy_d;

  always_comb begin
    rem_d  = rem_q;
    quad_d = quad_q;
    busy_d = busy_q;
    done_c = busy_q && (rem_q < ANGLE_W'(QUAD_DEG));
    if (start) begin
      rem_d  = angle;
      quad_d = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      if (done_c) begin
        busy_d = 1'b0;
      end else begin
        rem_d  = rem_q - ANGLE_W'(QUAD_DEG);
        quad_d = quad_q + QUAD_W'(1);
      end
    end
  end

  // Odd quadrants mirror the remainder about 90 degrees.
  always_comb begin
    quad_c = quad_q;
    ref_c  = quad_q[0] ? (DATA_WIDTH'(QUAD_DEG) - DATA_WIDTH'(rem_q)) : DATA_WIDTH'(rem_q);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rem_q  <= '0;
      quad_q <= '0;
      busy_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quad_q <= quad_d;
      busy_q <= busy_d;
    end
  end

endmodule

// File: rtl/trig_lut_sequencer.sv
// Two-requester front end for the shared trig LUT datapath.
// Define TRIG_SEQ_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module trig_lut_sequencer
  import trig_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ANGLE_W    = 9
) (
  input  logic                    clk,
  input  logic                    reset_n,
  trig_lut_sequencer_if.slave     bus,
  output logic [FN_COUNT-1:0]     lut_en,
  output logic [QUAD_W-1:0]       lut_quadrant,
  output logic [DATA_WIDTH-1:0]   lut_angle,
  input  logic [2*DATA_WIDTH-1:0] lut_data
);

  state_e                  state_q, state_d;
  logic [FUNC_W-1:0]       func_q, func_d;
  logic [FN_COUNT-1:0]     lut_en_q, lut_en_d;
  logic [QUAD_W-1:0]       lut_quad_q, lut_quad_d;
  logic [DATA_WIDTH-1:0]   lut_angle_q, lut_angle_d;
  logic                    resp_valid_q, resp_valid_d;
  logic [2*DATA_WIDTH-1:0] resp_data_q, resp_data_d;
  logic                    resp_id_q, resp_id_d;
  logic                    resp_err_q, resp_err_d;

  logic                    grant_c;
  logic                    grant_id_c;
  logic [FUNC_W-1:0]       acc_func_c;
  logic [ANGLE_W-1:0]      acc_angle_c;
  logic                    acc_err_c;
  logic                    red_done_c;
  logic [QUAD_W-1:0]       red_quad_c;
  logic [DATA_WIDTH-1:0]   red_ref_c;

`ifdef TRIG_SEQ_RR_EN
  logic rr_q, rr_d;

  always_comb begin
    grant_id_c = bus.req_valid[rr_q] ? rr_q : ~rr_q;
    rr_d       = rr_q;
    if (grant_c) rr_d = ~grant_id_c;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) rr_q <= 1'b0;
    else          rr_q <= rr_d;
  end
`else
  always_comb grant_id_c = ~bus.req_valid[0];
`endif

  // Ready goes only to the winner, only in IDLE, and never while reset is held.
  always_comb begin
    grant_c       = reset_n && (state_q == ST_IDLE) && (bus.req_valid != 2'b00);
    bus.req_ready = grant_c ? (2'b01 << grant_id_c) : 2'b00;
    acc_func_c    = grant_id_c ? bus.req_func1  : bus.req_func0;
    acc_angle_c   = grant_id_c ? bus.req_angle1 : bus.req_angle0;
    acc_err_c     = (acc_func_c >= FUNC_W'(FN_COUNT)) || (acc_angle_c >= ANGLE_W'(FULL_DEG));
  end

  trig_angle_reduce #(
    .ANGLE_W    (ANGLE_W),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_reduce (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (grant_c && !acc_err_c),
    .angle   (acc_angle_c),
    .done_c  (red_done_c),
    .quad_c  (red_quad_c),
    .ref_c   (red_ref_c)
  );

  always_comb begin
    state_d      = state_q;
    func_d       = func_q;
    lut_en_d     = lut_en_q;
    lut_quad_d   = lut_quad_q;
    lut_angle_d  = lut_angle_q;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    resp_id_d    = resp_id_q;
    resp_err_d   = resp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_c) begin
          func_d    = acc_func_c;
          resp_id_d = grant_id_c;
          if (acc_err_c) begin
            resp_err_d  = 1'b1;
            resp_data_d = '0;
            state_d     = ST_RESP;
          end else begin
            resp_err_d = 1'b0;
            state_d    = ST_REDUCE;
          end
        end
      end
      ST_REDUCE: begin
        if (red_done_c) begin
          lut_en_d    = fn_onehot(func_q);
          lut_quad_d  = red_quad_c;
          lut_angle_d = red_ref_c;
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_CAPTURE;
      // LUT output is valid one edge after the enable, so sample at the end of CAPTURE.
      ST_CAPTURE: begin
        resp_data_d = lut_data;
        lut_en_d    = '0;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        resp_valid_d = 1'b1;
        if (resp_valid_q && bus.resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      func_q       <= '0;
      lut_en_q     <= '0;
      lut_quad_q   <= '0;
      lut_angle_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_id_q    <= 1'b0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      func_q       <= func_d;
      lut_en_q     <= lut_en_d;
      lut_quad_q   <= lut_quad_d;
      lut_angle_q  <= lut_angle_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_id_q    <= resp_id_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign lut_en         = lut_en_q;
  assign lut_quadrant   = lut_quad_q;
  assign lut_angle      = lut_angle_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.resp_id    = resp_id_q;
  assign bus.resp_err   = resp_err_q;

endmodule
